// File: rtl/bus_bridge_demux.sv
// CPU-to-device bridge: decodes one CPU access onto DM/TC0/TC1, waits for the
// selected device's ack (bounded by TIMEOUT) and returns a one-cycle response.
module bus_bridge_demux #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        busy,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    output logic [3:0]  dev_byteen,
    output logic        dm_sel,
    output logic        tc0_sel,
    output logic        tc1_sel,
    input  logic [31:0] dm_rdata,
    input  logic [31:0] tc0_rdata,
    input  logic [31:0] tc1_rdata,
    input  logic        dm_ack,
    input  logic        tc0_ack,
    input  logic        tc1_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    // One-hot select {tc1, tc0, dm}; timer windows only accept full-word or read accesses.
    function automatic logic [2:0] decode(input logic [31:0] addr, input logic [3:0] be);
        logic tc_ok;
        tc_ok = (be == 4'b0000) || (be == 4'b1111);
        if (addr <= 32'h0000_2FFF) begin
            decode = 3'b001;
        end else if ((addr >= 32'h0000_7F00) && (addr <= 32'h0000_7F0B) && tc_ok) begin
            decode = 3'b010;
        end else if ((addr >= 32'h0000_7F10) && (addr <= 32'h0000_7F1B) && tc_ok) begin
            decode = 3'b100;
        end else begin
            decode = 3'b000;
        end
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [31:0]   dev_addr_q, dev_addr_d;
    logic [31:0]   dev_wdata_q, dev_wdata_d;
    logic [3:0]    dev_byteen_q, dev_byteen_d;

    logic [2:0]    hit_s;
    logic          ack_hit_s;
    logic [31:0]   sel_rdata_s;
    logic [CW-1:0] cnt_inc_s;

    // Decode of the incoming request and response data of the currently selected device.
    always_comb begin
        hit_s     = decode(cpu_addr, cpu_byteen);
        ack_hit_s = |(sel_q & {tc1_ack, tc0_ack, dm_ack});
        cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CW'(1));
        case (sel_q)
            3'b001:  sel_rdata_s = dm_rdata;
            3'b010:  sel_rdata_s = tc0_rdata;
            3'b100:  sel_rdata_s = tc1_rdata;
            default: sel_rdata_s = 32'h0000_0000;
        endcase
    end

    // Next-state and next-output logic for the IDLE/WAIT/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        rdata_d      = rdata_q;
        ack_d        = 1'b0;
        err_d        = err_q;
        busy_d       = busy_q;
        dev_addr_d   = dev_addr_q;
        dev_wdata_d  = dev_wdata_q;
        dev_byteen_d = dev_byteen_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    dev_addr_d   = cpu_addr;
                    dev_wdata_d  = cpu_wdata;
                    dev_byteen_d = cpu_byteen;
                    busy_d       = 1'b1;
                    if (hit_s != 3'b000) begin
                        sel_d   = hit_s;
                        cnt_d   = {CW{1'b0}};
                        state_d = S_WAIT;
                    end else begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 32'h0000_0000;
                        state_d = S_RESP;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (ack_hit_s) begin
                    rdata_d = (dev_byteen_q == 4'b0000) ? sel_rdata_s : 32'h0000_0000;
                    err_d   = 1'b0;
                    ack_d   = 1'b1;
                    sel_d   = 3'b000;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc_s;
                    // This cycle's increment brings the count to TIMEOUT.
                    if (cnt_q >= CNT_LAST) begin
                        rdata_d = 32'h0000_0000;
                        err_d   = 1'b1;
                        ack_d   = 1'b1;
                        sel_d   = 3'b000;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_RESP: begin
                busy_d  = 1'b0;
                sel_d   = 3'b000;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                sel_d   = 3'b000;
                cnt_d   = {CW{1'b0}};
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CW{1'b0}};
            sel_q        <= 3'b000;
            rdata_q      <= 32'h0000_0000;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            dev_addr_q   <= 32'h0000_0000;
            dev_wdata_q  <= 32'h0000_0000;
            dev_byteen_q <= 4'b0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            rdata_q      <= rdata_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            dev_addr_q   <= dev_addr_d;
            dev_wdata_q  <= dev_wdata_d;
            dev_byteen_q <= dev_byteen_d;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_ack    = ack_q;
    assign cpu_err    = err_q;
    assign busy       = busy_q;
    assign dev_addr   = dev_addr_q;
    assign dev_wdata  = dev_wdata_q;
    assign dev_byteen = dev_byteen_q;
    assign dm_sel     = sel_q[0];
    assign tc0_sel    = sel_q[1];
    assign tc1_sel    = sel_q[2];

endmodule

// File: tb/tb_bus_bridge_demux.sv
// Randomized and directed bench for bus_bridge_demux against a transaction-level
// model: each access's select window, latency and response are predicted up front.
module tb_bus_bridge_demux;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, cpu_err, busy;
    logic [31:0] dev_addr, dev_wdata;
    logic [3:0]  dev_byteen;
    logic        dm_sel, tc0_sel, tc1_sel;
    logic [31:0] dm_rdata, tc0_rdata, tc1_rdata;
    logic        dm_ack, tc0_ack, tc1_ack;

    int total = 0;
    int bad   = 0;

    bus_bridge_demux #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .busy(busy),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_byteen(dev_byteen),
        .dm_sel(dm_sel), .tc0_sel(tc0_sel), .tc1_sel(tc1_sel),
        .dm_rdata(dm_rdata), .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata),
        .dm_ack(dm_ack), .tc0_ack(tc0_ack), .tc1_ack(tc1_ack)
    );

    always #5 clk = ~clk;

    // One CPU access. ack_at = WAIT cycle (1-based) in which the target device acks, 0 = never.
    task automatic do_access(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rd, input bit stray, input bit hold_req);
        int          region;
        bit          mapped, acked;
        int          nsel;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [2:0]  exp_sel, want_sel, obs_sel;
        if (addr < 32'h3000) region = 0;
        else if (addr >= 32'h7F00 && addr < 32'h7F0C) region = 1;
        else if (addr >= 32'h7F10 && addr < 32'h7F1C) region = 2;
        else region = 3;
        mapped  = (region == 0) || (region < 3 && (be == 4'h0 || be == 4'hF));
        acked   = (ack_at >= 1) && (ack_at <= TO);
        nsel    = !mapped ? 0 : (acked ? ack_at : TO);
        exp_err = !mapped || !acked;
        exp_rd  = (!exp_err && be == 4'h0) ? rd : 32'h0;
        exp_sel = mapped ? (3'b001 << region) : 3'b000;

        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = addr; cpu_wdata = wd; cpu_byteen = be;
        for (int k = 1; k <= nsel + 2; k++) begin
            @(negedge clk);
            obs_sel  = {tc1_sel, tc0_sel, dm_sel};
            want_sel = (k <= nsel) ? exp_sel : 3'b000;
            total++;
            if (obs_sel !== want_sel) begin
                bad++;
                $display("FAIL sel addr=%h cyc=%0d got=%b want=%b", addr, k, obs_sel, want_sel);
            end
            total++;
            if (busy !== (k <= nsel + 1)) begin
                bad++;
                $display("FAIL busy addr=%h cyc=%0d got=%b want=%b", addr, k, busy, (k <= nsel + 1));
            end
            total++;
            if (cpu_ack !== (k == nsel + 1)) begin
                bad++;
                $display("FAIL cpu_ack addr=%h cyc=%0d got=%b want=%b", addr, k, cpu_ack, (k == nsel + 1));
            end
            if (k >= nsel + 1) begin
                total++;
                if (cpu_rdata !== exp_rd || cpu_err !== exp_err) begin
                    bad++;
                    $display("FAIL resp addr=%h cyc=%0d got rdata=%h err=%b want rdata=%h err=%b",
                             addr, k, cpu_rdata, cpu_err, exp_rd, exp_err);
                end
            end
            if (k <= nsel) begin
                total++;
                if ({dev_addr, dev_wdata, dev_byteen} !== {addr, wd, be}) begin
                    bad++;
                    $display("FAIL dev_bus cyc=%0d got=%h/%h/%h want=%h/%h/%h",
                             k, dev_addr, dev_wdata, dev_byteen, addr, wd, be);
                end
            end
            dm_ack = 1'b0; tc0_ack = 1'b0; tc1_ack = 1'b0;
            dm_rdata = $urandom; tc0_rdata = $urandom; tc1_rdata = $urandom;
            if (k == ack_at) begin
                case (region)
                    0: begin dm_ack = 1'b1;  dm_rdata = rd;  end
                    1: begin tc0_ack = 1'b1; tc0_rdata = rd; end
                    2: begin tc1_ack = 1'b1; tc1_rdata = rd; end
                    default: ;
                endcase
            end
            if (stray && region != 1) tc0_ack = (k % 2 == 1);
            cpu_req = hold_req && (k <= nsel + 1);
            if (hold_req) begin
                cpu_addr = 32'h0000_7F10; cpu_wdata = $urandom; cpu_byteen = 4'hF;
            end
        end
        dm_ack = 1'b0; tc0_ack = 1'b0; tc1_ack = 1'b0; cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        total++;
        if ({cpu_ack, cpu_err, busy, dm_sel, tc0_sel, tc1_sel} !== 6'b0 ||
            {cpu_rdata, dev_addr, dev_wdata, dev_byteen} !== 100'b0) begin
            bad++;
            $display("FAIL reset_state got ack=%b err=%b busy=%b sel=%b%b%b rdata=%h daddr=%h want all zero",
                     cpu_ack, cpu_err, busy, tc1_sel, tc0_sel, dm_sel, cpu_rdata, dev_addr);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_dm_read();
        do_access(32'h0000_0010, 4'h0, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    endtask

    task automatic test_tc1_write();
        do_access(32'h0000_7F14, 4'hF, 32'h0000_0005, 3, 32'h1234_5678, 1'b0, 1'b0);
    endtask

    task automatic test_unmapped();
        do_access(32'h0000_4000, 4'h0, 32'h0, 1, 32'h1111_1111, 1'b0, 1'b0);
        do_access(32'h0000_7F04, 4'b0011, 32'hABCD, 1, 32'h2222_2222, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        do_access(32'h0000_0100, 4'h0, 32'h0, 0, 32'h3333_3333, 1'b0, 1'b0);
        do_access(32'h0000_0104, 4'h0, 32'h0, TO, 32'h4444_4444, 1'b0, 1'b0);
    endtask

    task automatic test_stray_busy();
        do_access(32'h0000_0200, 4'h0, 32'h0, 5, 32'h5555_AAAA, 1'b1, 1'b1);
    endtask

    task automatic test_boundaries();
        do_access(32'h0000_2FFF, 4'h0, 32'h0, 2, 32'hA0A0_0001, 1'b0, 1'b0);
        do_access(32'h0000_7F0B, 4'h0, 32'h0, 1, 32'hA0A0_0002, 1'b0, 1'b0);
        do_access(32'h0000_7F1B, 4'h0, 32'h0, 2, 32'hA0A0_0003, 1'b0, 1'b0);
        do_access(32'h0000_3000, 4'h0, 32'h0, 1, 32'hA0A0_0004, 1'b0, 1'b0);
        do_access(32'h0000_7F0C, 4'hF, 32'h0, 1, 32'hA0A0_0005, 1'b0, 1'b0);
        do_access(32'h0000_7F1C, 4'h0, 32'h0, 1, 32'hA0A0_0006, 1'b0, 1'b0);
        do_access(32'h0000_7EFF, 4'h0, 32'h0, 1, 32'hA0A0_0007, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h0000_0300; cpu_wdata = 32'h0; cpu_byteen = 4'h0;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        total++;
        if (dm_sel !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_wait got sel=%b busy=%b want sel=1 busy=1", dm_sel, busy);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({dm_sel, tc0_sel, tc1_sel, busy, cpu_ack} !== 5'b0 || dev_addr !== 32'h0) begin
            bad++;
            $display("FAIL async_reset got sel=%b%b%b busy=%b ack=%b daddr=%h want zeros",
                     tc1_sel, tc0_sel, dm_sel, busy, cpu_ack, dev_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        dm_ack = 1'b1; dm_rdata = 32'hBAD0_BAD0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({cpu_ack, busy, dm_sel} !== 3'b000) begin
                bad++;
                $display("FAIL post_reset cyc=%0d got ack=%b busy=%b sel=%b want 000", k, cpu_ack, busy, dm_sel);
            end
        end
        dm_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] um [6];
        logic [31:0] addr;
        logic [3:0]  be;
        int          r;
        um = '{32'h0000_3000, 32'h0000_7EFF, 32'h0000_7F0C, 32'h0000_7F0F, 32'h0000_7F1C, 32'h0000_4000};
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 4);
            case (r)
                0:       addr = $urandom_range(0, 32'h2FFF);
                1:       addr = 32'h7F00 + $urandom_range(0, 11);
                2:       addr = 32'h7F10 + $urandom_range(0, 11);
                3:       addr = um[$urandom_range(0, 5)];
                default: addr = $urandom | 32'h0001_0000;
            endcase
            r = $urandom_range(0, 3);
            be = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom_range(1, 14));
            do_access(addr, be, $urandom, $urandom_range(0, TO + 2), $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        cpu_req = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_byteen = 4'h0;
        dm_rdata = 32'h0; tc0_rdata = 32'h0; tc1_rdata = 32'h0;
        dm_ack = 1'b0; tc0_ack = 1'b0; tc1_ack = 1'b0;
        test_reset();
        test_dm_read();
        test_tc1_write();
        test_unmapped();
        test_timeout();
        test_stray_busy();
        test_boundaries();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
